// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the register file slice.
package cpu_pkg;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  function automatic logic is_zero_reg(input reg_addr_t a);
    return a == reg_addr_t'(ZERO_REG);
  endfunction
endpackage

// File: rtl/regfile_array.sv
// 31x32 register storage: one synchronous write port, two asynchronous read ports.
module regfile_array
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  word_t mem_q [NUM_REGS-1:1];
  word_t mem_d [NUM_REGS-1:1];

  always_comb begin
    mem_d = mem_q;
    if (we && !is_zero_reg(waddr)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // r0 has no storage; it reads as a hardwired zero.
  always_comb begin
    rdata1 = is_zero_reg(raddr1) ? '0 : mem_q[raddr1];
    rdata2 = is_zero_reg(raddr2) ? '0 : mem_q[raddr2];
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback-stage register file with optional same-cycle forwarding and a
// per-register pending-write scoreboard that generates the decode stall.
module regfile_wb
  import cpu_pkg::*;
#(
  parameter int unsigned BYPASS = 1,
  parameter int unsigned PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write_w,
  input  logic                  mem_to_reg_w,
  input  logic [DATA_W-1:0]     alu_result_w,
  input  logic [DATA_W-1:0]     read_data_w,
  input  logic [REG_ADDR_W-1:0] write_reg_w,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic                  issue_d,
  input  logic [REG_ADDR_W-1:0] dest_d,
  output logic [DATA_W-1:0]     rd1_d,
  output logic [DATA_W-1:0]     rd2_d,
  output logic [DATA_W-1:0]     result_w,
  output logic                  stall_d,
  output logic                  sb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q [NUM_REGS-1:1];
  logic [PEND_W-1:0] pend_d [NUM_REGS-1:1];
  logic              sb_err_q, sb_err_d;
  logic              wb_en;
  logic              issue_eff;
  logic              stall_rs, stall_rt;
  word_t             arr_rd1, arr_rd2;

  assign result_w = mem_to_reg_w ? read_data_w : alu_result_w;
  assign wb_en    = reg_write_w && !is_zero_reg(write_reg_w);

  regfile_array u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (write_reg_w),
    .wdata  (result_w),
    .raddr1 (rs_d),
    .raddr2 (rt_d),
    .rdata1 (arr_rd1),
    .rdata2 (arr_rd2)
  );

  always_comb begin
    rd1_d = arr_rd1;
    rd2_d = arr_rd2;
    if (BYPASS != 0 && wb_en && write_reg_w == rs_d) rd1_d = result_w;
    if (BYPASS != 0 && wb_en && write_reg_w == rt_d) rd2_d = result_w;
  end

  // A last outstanding write that retires this cycle is forwarded, so it need not stall.
  function automatic logic src_stall(input reg_addr_t src, input logic [PEND_W-1:0] pend,
                                     input logic wb_hit);
    if (is_zero_reg(src) || pend == '0) return 1'b0;
    return !(BYPASS != 0 && pend == PEND_ONE && wb_hit);
  endfunction

  always_comb begin
    stall_rs  = src_stall(rs_d, is_zero_reg(rs_d) ? '0 : pend_q[rs_d],
                          wb_en && write_reg_w == rs_d);
    stall_rt  = src_stall(rt_d, is_zero_reg(rt_d) ? '0 : pend_q[rt_d],
                          wb_en && write_reg_w == rt_d);
    stall_d   = stall_rs || stall_rt;
    issue_eff = issue_d && !stall_d && !is_zero_reg(dest_d);
  end

  always_comb begin
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      logic inc, dec;
      inc = issue_eff && dest_d == reg_addr_t'(i);
      dec = wb_en && write_reg_w == reg_addr_t'(i);
      if (inc && !dec) begin
        if (pend_q[i] == PEND_MAX) sb_err_d = 1'b1;
        else                       pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (dec && !inc) begin
        if (pend_q[i] == '0) sb_err_d = 1'b1;
        else                 pend_d[i] = pend_q[i] - PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Drives two regfile_wb instances (BYPASS=0 and BYPASS=1) with the same stimulus
// and compares both against an array/counter reference model.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_write_w = 1'b0, mem_to_reg_w = 1'b0, issue_d = 1'b0;
  logic [31:0] alu_result_w = '0, read_data_w = '0;
  logic [4:0]  write_reg_w = '0, rs_d = '0, rt_d = '0, dest_d = '0;

  logic [31:0] rd1_0, rd2_0, res_0, rd1_1, rd2_1, res_1;
  logic        stall_0, err_0, stall_1, err_1;

  always #5 clk = ~clk;

  regfile_wb #(.BYPASS(0), .PEND_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w), .write_reg_w(write_reg_w),
    .rs_d(rs_d), .rt_d(rt_d), .issue_d(issue_d), .dest_d(dest_d),
    .rd1_d(rd1_0), .rd2_d(rd2_0), .result_w(res_0), .stall_d(stall_0), .sb_err(err_0));

  regfile_wb #(.BYPASS(1), .PEND_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w), .write_reg_w(write_reg_w),
    .rs_d(rs_d), .rt_d(rt_d), .issue_d(issue_d), .dest_d(dest_d),
    .rd1_d(rd1_1), .rd2_d(rd2_1), .result_w(res_1), .stall_d(stall_1), .sb_err(err_1));

  localparam int PEND_MAX = 3;

  logic [31:0] m_reg  [2][32];
  int          m_pend [2][32];
  bit          m_err  [2];

  int n_vec = 0, n_err = 0;

  logic [31:0] o_rd1 [2], o_rd2 [2];
  logic        o_stall [2], o_err [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int k, input logic [4:0] a, input logic [31:0] wbv);
    if (a == 0) return 32'h0;
    if (k == 1 && reg_write_w && write_reg_w == a) return wbv;
    return m_reg[k][a];
  endfunction

  function automatic bit m_src_stall(input int k, input logic [4:0] a);
    bit retiring;
    if (a == 0 || m_pend[k][a] == 0) return 1'b0;
    retiring = reg_write_w && write_reg_w == a && m_pend[k][a] == 1;
    return !(k == 1 && retiring);
  endfunction

  task automatic sample_outputs();
    o_rd1[0] = rd1_0; o_rd2[0] = rd2_0; o_stall[0] = stall_0; o_err[0] = err_0;
    o_rd1[1] = rd1_1; o_rd2[1] = rd2_1; o_stall[1] = stall_1; o_err[1] = err_1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r]  = '0;
        m_pend[k][r] = 0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  task automatic cyc(input logic we, input logic m2r, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [4:0] wr, input logic [4:0] rs,
                     input logic [4:0] rt, input logic iss, input logic [4:0] dest);
    logic [31:0] wbv;
    bit          st [2];
    bit          we_eff, iss_eff;
    @(negedge clk);
    reg_write_w = we; mem_to_reg_w = m2r; alu_result_w = alu; read_data_w = mem;
    write_reg_w = wr; rs_d = rs; rt_d = rt; issue_d = iss; dest_d = dest;
    #1;
    wbv = m2r ? mem : alu;
    sample_outputs();
    chk("result_w/byp0", res_0, wbv);
    chk("result_w/byp1", res_1, wbv);
    for (int k = 0; k < 2; k++) begin
      st[k] = m_src_stall(k, rs) || m_src_stall(k, rt);
      chk($sformatf("rd1/byp%0d", k), o_rd1[k], m_read(k, rs, wbv));
      chk($sformatf("rd2/byp%0d", k), o_rd2[k], m_read(k, rt, wbv));
      chk($sformatf("stall/byp%0d", k), {31'b0, o_stall[k]}, {31'b0, st[k]});
      chk($sformatf("sb_err/byp%0d", k), {31'b0, o_err[k]}, {31'b0, m_err[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      we_eff  = we && wr != 0;
      iss_eff = iss && !st[k] && dest != 0;
      if (we_eff) m_reg[k][wr] = wbv;
      if (!(we_eff && iss_eff && wr == dest)) begin
        if (iss_eff) begin
          if (m_pend[k][dest] == PEND_MAX) m_err[k] = 1'b1;
          else m_pend[k][dest]++;
        end
        if (we_eff) begin
          if (m_pend[k][wr] == 0) m_err[k] = 1'b1;
          else m_pend[k][wr]--;
        end
      end
    end
  endtask

  task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, rs, rt, 1'b0, 5'd0);
  endtask

  // Reset lands between edges; released again before the next posedge.
  task automatic hard_reset();
    @(negedge clk);
    reg_write_w = 1'b0; issue_d = 1'b0; rs_d = 5'd5; rt_d = 5'd7;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    sample_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_rd1/byp%0d", k), o_rd1[k], 32'h0);
      chk($sformatf("rst_rd2/byp%0d", k), o_rd2[k], 32'h0);
      chk($sformatf("rst_stall/byp%0d", k), {31'b0, o_stall[k]}, 32'h0);
      chk($sformatf("rst_err/byp%0d", k), {31'b0, o_err[k]}, 32'h0);
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    hard_reset();

    // Plain write/read and r0 behaviour
    cyc(1'b1, 1'b0, 32'hDEADBEEF, 32'h0BADF00D, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd5, 5'd0);
    chk("r5_read", o_rd1[0], 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd0, 5'd0);
    chk("r0_read", o_rd1[1], 32'h0);
    cyc(1'b1, 1'b1, 32'h1, 32'hCAFE0001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd9, 5'd5);
    chk("load_write", o_rd1[0], 32'hCAFE0001);

    // Same-cycle forwarding
    hard_reset();
    cyc(1'b1, 1'b0, 32'h11111111, 32'h0, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 32'h12345678, 32'h0, 5'd7, 5'd0, 5'd7, 1'b0, 5'd0);
    chk("fwd_byp1", o_rd2[1], 32'h12345678);
    chk("fwd_byp0", o_rd2[0], 32'h11111111);

    // Stall on pending source, released by retiring writeback when forwarding
    hard_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3);
    idle(5'd3, 5'd0);
    chk("stall_r3", {31'b0, o_stall[1]}, 32'h1);
    cyc(1'b1, 1'b0, 32'h33, 32'h0, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("retire_byp1", {31'b0, o_stall[1]}, 32'h0);
    chk("retire_byp0", {31'b0, o_stall[0]}, 32'h1);
    idle(5'd3, 5'd3);

    // Saturation at max and underflow at zero
    hard_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4);
    idle(5'd4, 5'd0);
    chk("sat_err", {31'b0, o_err[1]}, 32'h1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, i, 32'h0, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd4, 5'd0);
    chk("sat_drained", {31'b0, o_stall[0]}, 32'h0);
    hard_reset();
    cyc(1'b1, 1'b0, 32'h99, 32'h0, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd0, 5'd0);
    chk("underflow_err", {31'b0, o_err[0]}, 32'h1);

    // Issue and writeback to the same register cancel
    hard_reset();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6);
    cyc(1'b1, 1'b0, 32'h66, 32'h0, 5'd6, 5'd0, 5'd0, 1'b1, 5'd6);
    idle(5'd6, 5'd0);
    chk("cancel_stall", {31'b0, o_stall[1]}, 32'h1);
    cyc(1'b1, 1'b0, 32'h67, 32'h0, 5'd6, 5'd6, 5'd0, 1'b0, 5'd0);
    idle(5'd6, 5'd0);
    chk("cancel_err", {31'b0, o_err[1]}, 32'h0);

    // Randomized traffic over a narrow register window, with periodic resets
    for (int n = 0; n < 800; n++) begin
      if (n % 60 == 59) hard_reset();
      cyc(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
          $urandom, $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
          5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle writeback value forwarded to read ports.
REQ-002 SHALL have parameter PEND_W, default 2, meaning width of each per-register pending-write counter.
REQ-003 SHALL have port clk  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port reg_write_w  in  1  writeback enable.
REQ-006 SHALL have port mem_to_reg_w  in  1  1 = write read_data_w, 0 = write alu_result_w.
REQ-007 SHALL have port alu_result_w  in  32  ALU result.
REQ-008 SHALL have port read_data_w  in  32  memory load data.
REQ-009 SHALL have port write_reg_w  in  5  destination register.
REQ-010 SHALL have port rs_d  in  5  decode source register A.
REQ-011 SHALL have port rt_d  in  5  decode source register B.
REQ-012 SHALL have port issue_d  in  1  decode issues an instruction that will write dest_d.
REQ-013 SHALL have port dest_d  in  5  destination of the issuing instruction.
REQ-014 SHALL have port rd1_d  out  32  read data for rs_d.
REQ-015 SHALL have port rd2_d  out  32  read data for rt_d.
REQ-016 SHALL have port result_w  out  32  selected writeback value.
REQ-017 SHALL have port stall_d  out  1  decode must hold; a source has an unresolved pending write.
REQ-018 SHALL have port sb_err  out  1  sticky scoreboard overflow/underflow flag.

Function
REQ-019 result_w SHALL be mem_to_reg_w ? read_data_w : alu_result_w, combinational.
REQ-020 On posedge clk with reg_write_w=1 and write_reg_w!=0, register[write_reg_w] SHALL take result_w.
REQ-021 Writes to register 0 SHALL be discarded; reads of register 0 SHALL return 0.
REQ-022 Reads SHALL be combinational, zero latency.
REQ-023 With BYPASS=1, reg_write_w=1 and write_reg_w==rs_d!=0, rd1_d SHALL equal result_w in the same cycle; likewise rd2_d for rt_d.
REQ-024 With BYPASS=0, reads SHALL return stored contents only.
REQ-025 Each register 1..31 SHALL have a PEND_W-bit pending counter.
REQ-026 Effective issue SHALL be issue_d & !stall_d & (dest_d!=0); it increments pend[dest_d].
REQ-027 Writeback with reg_write_w=1 and write_reg_w!=0 SHALL decrement pend[write_reg_w].
REQ-028 Effective issue and writeback to the same register in the same cycle SHALL leave that counter unchanged.
REQ-029 Increment at maximum (3 for PEND_W=2) SHALL saturate and set sb_err.
REQ-030 Decrement at 0 SHALL hold 0 and set sb_err.
REQ-031 sb_err SHALL remain set until reset.
REQ-032 stall_d SHALL be 1 when either source is nonzero and its pend>0.
REQ-033 Exception to REQ-032: with BYPASS=1, a source with pend==1 that is written back this cycle SHALL NOT stall.
REQ-034 Register 0 SHALL never cause a stall.

Reset
REQ-035 On rst_n low, asynchronously, all 31 registers, all pending counters and sb_err SHALL clear to 0.
REQ-036 Reset mid-operation SHALL discard in-flight pending state; the first clk edge after release SHALL behave as from idle.

Structure
REQ-037 DATA_W=32, REG_ADDR_W=5 and ZERO_REG=0 SHALL live in shared package cpu_pkg.
REQ-038 Storage SHALL be sub-module regfile_array (31x32, 1 write, 2 async read ports); scoreboard and bypass stay in regfile_wb.

Verification
REQ-039 Write 0xDEADBEEF to r5 (mem_to_reg_w=0), next cycle rs_d=5 -> rd1_d=0xDEADBEEF; write to r0 -> rd1_d=0 with rs_d=0.
REQ-040 BYPASS=1: write r7=0x12345678 while rt_d=7 -> rd2_d=0x12345678 same cycle; BYPASS=0 -> old value.
REQ-041 Issue dest_d=3, next cycle rs_d=3 -> stall_d=1; writeback r3 with pend==1 -> stall_d=0 that cycle (BYPASS=1).
REQ-042 Issue r4 three times, then a fourth -> pend stays 3, sb_err=1; writeback r9 with pend 0 -> sb_err=1.
REQ-043 Issue and writeback r6 in the same cycle with pend=1 -> pend stays 1, stall_d stays 1 for rs_d=6.
REQ-044 Assert rst_n=0 mid-sequence -> all reads 0, stall_d=0, sb_err=0 immediately.
